ahbl_splitter_n: RTL and testbench

Parametrised AHB-Lite address decoder and response multiplexer connecting one master to `NS` slaves, selected by the top `SEL_BITS` of `HADDR`. It replaces the fixed four-way splitter in the SoC interconnect. Unmapped accesses go to a built-in default slave that returns a two-cycle ERROR response. A stall watchdog flags any slave that holds `HREADYOUT` low for too long.

---
 rtl/ahbl_splitter_n.sv | 158 +++++++++++++++
 tb/tb_ahbl_splitter_n.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_splitter_n.sv
// rtl/ahbl_splitter_n.sv - AHB-Lite one-master to NS-slave decoder and response mux
// Includes an error-responding default slave and a stall watchdog.
module ahbl_splitter_n #(
    parameter int                          NS       = 4,
    parameter int                          SEL_BITS = 4,
    parameter logic [NS*SEL_BITS-1:0]      S_BASE   = {4'h8, 4'h4, 4'h2, 4'h0},
    parameter int                          TIMEOUT  = 256
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    output logic                 HREADY,
    output logic [31:0]          HRDATA,
    output logic                 HRESP,
    output logic [NS-1:0]        S_HSEL,
    input  logic [NS*32-1:0]     S_HRDATA,
    input  logic [NS-1:0]        S_HREADYOUT,
    input  logic [NS-1:0]        S_HRESP,
    output logic                 TO_FLAG,
    output logic [3:0]           TO_SLAVE,
    input  logic                 TO_CLR
);

    typedef enum logic [1:0] {
        E_IDLE,
        E_ERR1,
        E_ERR2
    } err_state_t;

    localparam logic [15:0] TO_VAL = 16'(TIMEOUT);
    localparam bit          WD_EN  = (TIMEOUT != 0);

    logic [SEL_BITS-1:0] tag;
    logic [NS-1:0]       hsel;
    logic                found;
    logic                def_hit;
    logic                accept;

    logic [NS-1:0]       dsel_q, dsel_d;
    logic                dsel_def_q, dsel_def_d;
    err_state_t          err_q, err_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                to_flag_q, to_flag_d;
    logic [3:0]          to_slave_q, to_slave_d;

    logic                hready;
    logic                hresp;
    logic [31:0]         hrdata;
    logic                stall;
    logic [3:0]          stall_idx;
    logic                to_set;
    logic                unused_bits;

    assign tag         = HADDR[31 -: SEL_BITS];
    assign unused_bits = ^{HADDR[31-SEL_BITS:0], HTRANS[0]};

    // Priority decode: lowest matching index wins, keeping S_HSEL one-hot or zero.
    always_comb begin
        hsel  = '0;
        found = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (!found && tag == S_BASE[i*SEL_BITS +: SEL_BITS]) begin
                hsel[i] = 1'b1;
                found   = 1'b1;
            end
        end
        def_hit = !found && HTRANS[1];
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        for (int i = 0; i < NS; i++) begin
            if (dsel_q[i]) begin
                hready = S_HREADYOUT[i];
                hresp  = S_HRESP[i];
                hrdata = S_HRDATA[i*32 +: 32];
            end
        end
        if (dsel_def_q) begin
            hrdata = 32'hBADD_BEEF;
            hready = (err_q != E_ERR1);
            hresp  = (err_q != E_IDLE);
        end
    end

    assign accept = hready && def_hit;

    always_comb begin
        dsel_d     = dsel_q;
        dsel_def_d = dsel_def_q;
        if (hready) begin
            dsel_d     = HTRANS[1] ? hsel : '0;
            dsel_def_d = def_hit;
        end
    end

    always_comb begin
        err_d = err_q;
        case (err_q)
            E_IDLE:  err_d = accept ? E_ERR1 : E_IDLE;
            E_ERR1:  err_d = E_ERR2;
            E_ERR2:  err_d = accept ? E_ERR1 : E_IDLE;
            default: err_d = E_IDLE;
        endcase
    end

    always_comb begin
        stall     = (|dsel_q) && !hready;
        stall_idx = '0;
        for (int i = 0; i < NS; i++) begin
            if (dsel_q[i]) begin
                stall_idx = 4'(i);
            end
        end
    end

    // Flag fires only on the edge the counter lands on TIMEOUT; saturation stops re-triggering.
    always_comb begin
        cnt_d = cnt_q;
        if (hready) begin
            cnt_d = '0;
        end else if (WD_EN && stall && cnt_q != TO_VAL) begin
            cnt_d = cnt_q + 16'd1;
        end
        to_set     = WD_EN && stall && (cnt_q == TO_VAL - 16'd1);
        to_flag_d  = to_set || (to_flag_q && !TO_CLR);
        to_slave_d = (to_set && !to_flag_q) ? stall_idx : to_slave_q;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_q     <= '0;
            dsel_def_q <= 1'b0;
            err_q      <= E_IDLE;
            cnt_q      <= '0;
            to_flag_q  <= 1'b0;
            to_slave_q <= '0;
        end else begin
            dsel_q     <= dsel_d;
            dsel_def_q <= dsel_def_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            to_flag_q  <= to_flag_d;
            to_slave_q <= to_slave_d;
        end
    end

    assign S_HSEL   = hsel;
    assign HREADY   = hready;
    assign HRESP    = hresp;
    assign HRDATA   = hrdata;
    assign TO_FLAG  = to_flag_q;
    assign TO_SLAVE = to_slave_q;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// tb/tb_ahbl_splitter_n.sv - self-checking bench for ahbl_splitter_n
// Fixed vector table, directed watchdog/reset sequences, randomized traffic vs reference model.
module tb_ahbl_splitter_n;

    localparam int NS   = 4;
    localparam int TOUT = 8;

    logic               HCLK = 1'b0;
    logic               HRESET;
    logic [31:0]        HADDR;
    logic [1:0]         HTRANS;
    logic               HREADY;
    logic [31:0]        HRDATA;
    logic               HRESP;
    logic [NS-1:0]      S_HSEL;
    logic [NS*32-1:0]   S_HRDATA;
    logic [NS-1:0]      S_HREADYOUT;
    logic [NS-1:0]      S_HRESP;
    logic               TO_FLAG;
    logic [3:0]         TO_SLAVE;
    logic               TO_CLR;

    ahbl_splitter_n #(
        .NS(NS), .SEL_BITS(4), .S_BASE(16'h8420), .TIMEOUT(TOUT)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .S_HSEL(S_HSEL),
        .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .TO_FLAG(TO_FLAG), .TO_SLAVE(TO_SLAVE), .TO_CLR(TO_CLR)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: data-phase target as an integer (-1 none, 0..NS-1 slave, NS default).
    int          bases[NS] = '{0, 2, 4, 8};
    int          m_tgt;
    bit          m_err1;
    int          m_cnt;
    bit          m_flag;
    int          m_slv;
    logic        e_ready;

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (int'(a[31:28]) == bases[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_tgt = -1; m_err1 = 0; m_cnt = 0; m_flag = 0; m_slv = 0;
    endtask

    task automatic settle();
        int          d;
        logic [3:0]  e_hsel;
        logic        e_resp;
        logic [31:0] e_data;
        #3;
        d      = decode(HADDR);
        e_hsel = (d >= 0) ? 4'(1 << d) : 4'b0;
        if (m_tgt < 0) begin
            e_ready = 1'b1; e_resp = 1'b0; e_data = 32'h0;
        end else if (m_tgt == NS) begin
            e_ready = !m_err1; e_resp = 1'b1; e_data = 32'hBADD_BEEF;
        end else begin
            e_ready = S_HREADYOUT[m_tgt];
            e_resp  = S_HRESP[m_tgt];
            e_data  = S_HRDATA[m_tgt*32 +: 32];
        end
        chk("m_hsel",     S_HSEL,   e_hsel);
        chk("m_hready",   HREADY,   e_ready);
        chk("m_hresp",    HRESP,    e_resp);
        chk("m_hrdata",   HRDATA,   e_data);
        chk("m_to_flag",  TO_FLAG,  m_flag);
        chk("m_to_slave", TO_SLAVE, m_slv);
    endtask

    task automatic advance();
        int d;
        bit set;
        @(posedge HCLK);
        d   = decode(HADDR);
        set = 0;
        if (e_ready) begin
            m_cnt = 0;
        end else if (m_tgt >= 0 && m_tgt < NS && m_cnt < TOUT) begin
            m_cnt++;
            if (m_cnt == TOUT) set = 1;
        end
        if (set && !m_flag) m_slv = m_tgt;
        m_flag = set ? 1'b1 : (TO_CLR ? 1'b0 : m_flag);
        if (e_ready) begin
            m_tgt  = HTRANS[1] ? ((d >= 0) ? d : NS) : -1;
            m_err1 = (m_tgt == NS);
        end else begin
            m_err1 = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1; HTRANS = 2'b00; TO_CLR = 1'b0; S_HREADYOUT = '1; S_HRESP = '0;
        model_reset();
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [3:0]  rdy;
        logic [3:0]  resp;
        logic [3:0]  e_hsel;
        logic        e_ready;
        logic        e_resp;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[19];

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h0000_0010, 2'd2, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{32'h2000_0000, 2'd2, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, 32'hA0A0_0000};
        tbl[2]  = '{32'hC000_0000, 2'd2, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'hA1A1_0001};
        tbl[3]  = '{32'h4000_0000, 2'd2, 4'b1111, 4'b0000, 4'b0100, 1'b0, 1'b1, 32'hBADD_BEEF};
        tbl[4]  = '{32'h4000_0000, 2'd2, 4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b1, 32'hBADD_BEEF};
        tbl[5]  = '{32'h8000_0000, 2'd2, 4'b1011, 4'b0000, 4'b1000, 1'b0, 1'b0, 32'hA2A2_0002};
        tbl[6]  = '{32'h8000_0000, 2'd2, 4'b1011, 4'b0000, 4'b1000, 1'b0, 1'b0, 32'hA2A2_0002};
        tbl[7]  = '{32'h8000_0000, 2'd2, 4'b1011, 4'b0000, 4'b1000, 1'b0, 1'b0, 32'hA2A2_0002};
        tbl[8]  = '{32'h8000_0000, 2'd2, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, 32'hA2A2_0002};
        tbl[9]  = '{32'hC000_0000, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'hA3A3_0003};
        tbl[10] = '{32'hC000_0000, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{32'h0000_0000, 2'd2, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b0, 32'h0};
        tbl[12] = '{32'h2000_0000, 2'd3, 4'b1111, 4'b0001, 4'b0010, 1'b1, 1'b1, 32'hA0A0_0000};
        tbl[13] = '{32'hC000_0000, 2'd2, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'hA1A1_0001};
        tbl[14] = '{32'hC000_0000, 2'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'hBADD_BEEF};
        tbl[15] = '{32'hC000_0000, 2'd2, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'hBADD_BEEF};
        tbl[16] = '{32'h0000_0000, 2'd0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b1, 32'hBADD_BEEF};
        tbl[17] = '{32'h0000_0000, 2'd0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b1, 32'hBADD_BEEF};
        tbl[18] = '{32'h0000_0000, 2'd0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h0};

        HRESET      = 1'b1;
        HADDR       = 32'h2000_0000;
        HTRANS      = 2'b00;
        S_HRDATA    = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        S_HREADYOUT = '1;
        S_HRESP     = '0;
        TO_CLR      = 1'b0;
        model_reset();

        #3;
        chk("rst_hready",   HREADY,   1);
        chk("rst_hresp",    HRESP,    0);
        chk("rst_hrdata",   HRDATA,   0);
        chk("rst_to_flag",  TO_FLAG,  0);
        chk("rst_to_slave", TO_SLAVE, 0);
        chk("rst_hsel",     S_HSEL,   4'b0010);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        for (int r = 0; r < 19; r++) begin
            HADDR = tbl[r].addr; HTRANS = tbl[r].trans;
            S_HREADYOUT = tbl[r].rdy; S_HRESP = tbl[r].resp;
            #3;
            chk($sformatf("tbl%0d_hsel", r),   S_HSEL, tbl[r].e_hsel);
            chk($sformatf("tbl%0d_hready", r), HREADY, tbl[r].e_ready);
            chk($sformatf("tbl%0d_hresp", r),  HRESP,  tbl[r].e_resp);
            chk($sformatf("tbl%0d_hrdata", r), HRDATA, tbl[r].e_data);
            @(posedge HCLK);
            #1;
        end

        do_reset();

        // Slave 3 stalls 10 cycles with TIMEOUT = 8.
        HADDR = 32'h8000_0000; HTRANS = 2'd2;
        settle(); advance();
        HADDR = 32'h0; HTRANS = 2'd0; S_HREADYOUT = 4'b0111;
        for (int k = 1; k <= 10; k++) begin
            settle();
            chk($sformatf("wd1_ready_k%0d", k), HREADY, 0);
            chk($sformatf("wd1_flag_k%0d", k), TO_FLAG, (k >= 9) ? 1 : 0);
            advance();
        end
        S_HREADYOUT = '1;
        settle();
        chk("wd1_sticky_flag", TO_FLAG, 1);
        chk("wd1_to_slave", TO_SLAVE, 3);
        advance();
        TO_CLR = 1'b1;
        settle(); advance();
        TO_CLR = 1'b0;
        settle();
        chk("wd_clr_flag", TO_FLAG, 0);

        // Slave 1 stalls; clear coincides with the timeout edge, then reset lands in the wait state.
        HADDR = 32'h2000_0000; HTRANS = 2'd2;
        advance();
        HADDR = 32'h0; HTRANS = 2'd0; S_HREADYOUT = 4'b1101;
        for (int k = 1; k <= 9; k++) begin
            TO_CLR = (k == 8);
            settle();
            if (k < 9) begin
                chk($sformatf("wd2_flag_k%0d", k), TO_FLAG, 0);
                advance();
            end
        end
        chk("wd2_set_wins", TO_FLAG, 1);
        chk("wd2_to_slave", TO_SLAVE, 1);
        chk("rst1_pre_ready", HREADY, 0);
        HRESET = 1'b1;
        #1;
        chk("rst1_hready",  HREADY,  1);
        chk("rst1_hresp",   HRESP,   0);
        chk("rst1_hrdata",  HRDATA,  0);
        chk("rst1_to_flag", TO_FLAG, 0);
        model_reset();
        @(posedge HCLK);
        #1;
        HRESET = 1'b0; S_HREADYOUT = '1;

        // Reset during ERR1 of a default-slave access.
        HADDR = 32'hC000_0000; HTRANS = 2'd2;
        settle(); advance();
        HTRANS = 2'd0;
        settle();
        chk("err1_hready", HREADY, 0);
        chk("err1_hresp",  HRESP,  1);
        chk("err1_hrdata", HRDATA, 32'hBADD_BEEF);
        HRESET = 1'b1;
        #1;
        chk("rst2_hready",  HREADY,  1);
        chk("rst2_hresp",   HRESP,   0);
        chk("rst2_hrdata",  HRDATA,  0);
        chk("rst2_to_flag", TO_FLAG, 0);
        model_reset();
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Randomized traffic; odd 100-cycle phases make slaves slow to provoke timeouts.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] r;
            logic [3:0]  nib;
            bit          slow;
            slow = ((c / 100) % 2) == 1;
            r = $urandom();
            case ($urandom_range(0, 5))
                0:       nib = 4'h0;
                1:       nib = 4'h2;
                2:       nib = 4'h4;
                3:       nib = 4'h8;
                4:       nib = 4'hC;
                default: nib = 4'($urandom_range(0, 15));
            endcase
            r[31:28] = nib;
            HADDR    = r;
            HTRANS   = 2'($urandom_range(0, 3));
            S_HRDATA = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int i = 0; i < NS; i++) begin
                S_HREADYOUT[i] = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
                S_HRESP[i]     = ($urandom_range(0, 7) == 0);
            end
            TO_CLR = ($urandom_range(0, 15) == 0);
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
